// File: rtl/decoder_grant_arbiter.sv
// decoder_grant_arbiter
//   Round-robin arbiter sharing one 3-to-8 enable-gated decoder among eight
//   requesters. A grant is held until its owner drops its request, and every
//   hand-over passes through one dead GAP cycle so the decoder outputs go
//   fully low between owners.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   -> 8-bit hold counter, forced release after MAX_HOLD grant
//                cycles, one-cycle timeout pulse during the following GAP.
//   undefined -> no counter; a grant lasts while req[sel]=1; timeout tied 0.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (1..255)
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req      in   [7:0] level-sensitive request lines, req[i] = requester i
//   sel      out  [2:0] decoder select (sel[2]=a MSB, sel[1]=b, sel[0]=c)
//   en       out  decoder enable, high only while a grant is active
//   gnt      out  [0:7] one-hot grant, gnt[i] = requester i owns the decoder
//   busy     out  high while in GRANT
//   timeout  out  one-cycle pulse in the GAP that follows a forced release
//
// Handshake: req[i] is a level; once granted, requester i owns the decoder
// for every cycle that en=1 and gnt[i]=1. Dropping req[i] (sampled at an
// edge) releases the grant at that edge. Request changes of other requesters
// during a grant are only seen at the next arbitration (IDLE or GAP).
// All outputs are registered; gnt always equals decode(sel) gated by en.

module decoder_grant_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       en,
  output logic [0:7] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Elaboration-time guard on the hold limit.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("decoder_grant_arbiter: MAX_HOLD out of range 1..255");
  end

  logic [1:0] state;
  logic [2:0] ptr;

  // Rotating-priority scan starting at ptr; first requester found wins.
  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int off = 0; off < 8; off++) begin
      cand = ptr + off[2:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  function automatic logic [0:7] decode(input logic [2:0] s);
    logic [0:7] d;
    d    = '0;
    d[s] = 1'b1;
    return d;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       hold_expired;
  // hold_cnt counts completed grant cycles minus one, so reaching
  // HOLD_LAST means en has now been high for MAX_HOLD cycles.
  assign hold_expired = (hold_cnt == HOLD_LAST);
`else
  logic hold_expired;
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      en       <= 1'b0;
      gnt      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE, ST_GAP: begin
          if (win_found) begin
            state    <= ST_GRANT;
            sel      <= win_idx;
            en       <= 1'b1;
            gnt      <= decode(win_idx);
            busy     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // A voluntary release wins over a coincident timeout.
          if (!req[sel] || hold_expired) begin
            state   <= ST_GAP;
            en      <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= sel + 3'd1;
            timeout <= req[sel];
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          en    <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// tb_decoder_grant_arbiter
//   Self-checking bench for decoder_grant_arbiter: a vector table of
//   {req, expected outputs after the next edge}, plus hand-written sequences
//   for async reset mid-grant, full round-robin and hold-time limit.
//   Expected output words go into exp_q when stimulus is driven and are
//   popped and compared #1 after the clock edge that produces them.
//   Expected word layout: {sel[2:0], en, gnt[0:7], busy, timeout}.

module tb_decoder_grant_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic [0:7] gnt;
  logic       busy;
  logic       timeout;

  decoder_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .en      (en),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int vectors_applied = 0;
  int miscompares     = 0;

  function automatic logic [13:0] ew(input logic [2:0] s, input logic e,
                                     input logic [0:7] g, input logic b,
                                     input logic t);
    return {s, e, g, b, t};
  endfunction

  // Owner o holding the decoder.
  function automatic logic [13:0] gw(input int o);
    logic [0:7] g;
    logic [2:0] s;
    s    = o[2:0];
    g    = '0;
    g[s] = 1'b1;
    return ew(s, 1'b1, g, 1'b1, 1'b0);
  endfunction

  // Decoder off, sel parked at s.
  function automatic logic [13:0] offw(input int s, input logic t);
    return ew(s[2:0], 1'b0, 8'b0, 1'b0, t);
  endfunction

  task automatic check(input string name);
    logic [13:0] e;
    logic [13:0] a;
    if (exp_q.size() == 0) begin
      vectors_applied++;
      miscompares++;
      $display("FAIL %s: expected queue empty, no required value", name);
      return;
    end
    e = exp_q.pop_front();
    a = {sel, en, gnt, busy, timeout};
    vectors_applied++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got sel=%b en=%b gnt=%b busy=%b timeout=%b, required sel=%b en=%b gnt=%b busy=%b timeout=%b",
               name, a[13:11], a[10], a[9:2], a[1], a[0],
               e[13:11], e[10], e[9:2], e[1], e[0]);
    end
  endtask

  // ---------------- driver ----------------
  // Drive req, expect e after the next rising edge.
  task automatic step(input logic [7:0] r, input logic [13:0] e, input string name);
    req = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  typedef struct {
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic [0:7] gnt;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // From reset: IDLE, ptr=0.
    tbl[0]  = '{8'h00, 3'd0, 1'b0, 8'b00000000, 1'b0, 1'b0}; // idle
    tbl[1]  = '{8'h20, 3'd5, 1'b1, 8'b00000100, 1'b1, 1'b0}; // single req 5
    tbl[2]  = '{8'h20, 3'd5, 1'b1, 8'b00000100, 1'b1, 1'b0}; // hold
    tbl[3]  = '{8'h00, 3'd5, 1'b0, 8'b00000000, 1'b0, 1'b0}; // release, ptr=6
    tbl[4]  = '{8'h00, 3'd5, 1'b0, 8'b00000000, 1'b0, 1'b0}; // IDLE, sel kept
    tbl[5]  = '{8'h0A, 3'd1, 1'b1, 8'b01000000, 1'b1, 1'b0}; // wrap: 1 not 3
    tbl[6]  = '{8'h0A, 3'd1, 1'b1, 8'b01000000, 1'b1, 1'b0};
    tbl[7]  = '{8'h08, 3'd1, 1'b0, 8'b00000000, 1'b0, 1'b0}; // drop 1, ptr=2
    tbl[8]  = '{8'h08, 3'd3, 1'b1, 8'b00010000, 1'b1, 1'b0}; // GAP arb -> 3
    tbl[9]  = '{8'h0C, 3'd3, 1'b1, 8'b00010000, 1'b1, 1'b0}; // req 2 ignored
    tbl[10] = '{8'h04, 3'd3, 1'b0, 8'b00000000, 1'b0, 1'b0}; // drop+rise, ptr=4
    tbl[11] = '{8'h04, 3'd2, 1'b1, 8'b00100000, 1'b1, 1'b0}; // wrap to 2
    tbl[12] = '{8'h00, 3'd2, 1'b0, 8'b00000000, 1'b0, 1'b0}; // ptr=3
    tbl[13] = '{8'h00, 3'd2, 1'b0, 8'b00000000, 1'b0, 1'b0};
    tbl[14] = '{8'h03, 3'd0, 1'b1, 8'b10000000, 1'b1, 1'b0}; // scan 3..7,0
    tbl[15] = '{8'h02, 3'd0, 1'b0, 8'b00000000, 1'b0, 1'b0}; // ptr=1
    tbl[16] = '{8'h03, 3'd1, 1'b1, 8'b01000000, 1'b1, 1'b0}; // 0 now lowest
    tbl[17] = '{8'h00, 3'd1, 1'b0, 8'b00000000, 1'b0, 1'b0}; // ptr=2
    tbl[18] = '{8'h00, 3'd1, 1'b0, 8'b00000000, 1'b0, 1'b0};
    tbl[19] = '{8'h08, 3'd3, 1'b1, 8'b00010000, 1'b1, 1'b0}; // grant 3
  end

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    req = 8'h00;
    #2;
    exp_q.push_back(offw(0, 1'b0));
    check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Vector table; ends with requester 3 holding the decoder.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].req,
           ew(tbl[i].sel, tbl[i].en, tbl[i].gnt, tbl[i].busy, tbl[i].to),
           $sformatf("tbl[%0d]", i));
    end

    // Async reset mid-grant: outputs drop with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(offw(0, 1'b0));
    check("async_reset_immediate");
    @(posedge clk);
    #1;
    rst = 1'b0;
    // ptr restarts at 0, so 0 beats 3.
    step(8'h09, gw(0), "post_reset_grant0");
    step(8'h00, offw(0, 1'b0), "post_reset_release");
    step(8'h00, offw(0, 1'b0), "post_reset_idle");

    // Fresh reset so round-robin starts from ptr=0.
    rst = 1'b1;
    #1;
    exp_q.push_back(offw(0, 1'b0));
    check("reset_before_rr");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full round-robin: each owner holds 2 cycles, drops, re-raises in GAP.
    step(8'hFF, gw(0), "rr_first_grant");
    for (int k = 0; k <= 8; k++) begin
      int o;
      logic [7:0] drop;
      o    = k % 8;
      drop = 8'hFF & ~(8'h01 << o);
      step(8'hFF, gw(o), $sformatf("rr_hold_%0d", k));
      if (k < 8) begin
        step(drop, offw(o, 1'b0), $sformatf("rr_gap_%0d", k));
        step(8'hFF, gw((o + 1) % 8), $sformatf("rr_grant_%0d", k + 1));
      end
    end
    step(8'h00, offw(0, 1'b0), "rr_final_gap");
    step(8'h00, offw(0, 1'b0), "rr_final_idle");

    // Hold-time limit: ptr=1 now, requester 2 held constantly.
`ifdef ARB_TIMEOUT_EN
    step(8'h04, gw(2), "to_grant");
    for (int c = 1; c < MAX_HOLD; c++) begin
      step(8'h04, gw(2), $sformatf("to_hold_%0d", c));
    end
    step(8'h04, offw(2, 1'b1), "to_forced_gap");
    step(8'h04, gw(2), "to_regrant");
    for (int c = 1; c < MAX_HOLD; c++) begin
      step(8'h04, gw(2), $sformatf("to_rehold_%0d", c));
    end
    // Drop on the same edge the limit is reached: voluntary, no pulse.
    step(8'h00, offw(2, 1'b0), "to_coincident_release");
    step(8'h00, offw(2, 1'b0), "to_idle");
`else
    step(8'h04, gw(2), "hold_grant");
    for (int c = 1; c < 3 * MAX_HOLD; c++) begin
      step(8'h04, gw(2), $sformatf("hold_unbounded_%0d", c));
    end
    step(8'h00, offw(2, 1'b0), "hold_release");
    step(8'h00, offw(2, 1'b0), "hold_idle");
`endif

    if (exp_q.size() != 0) begin
      vectors_applied++;
      miscompares++;
      $display("FAIL queue_drain: got %0d leftover entries, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
